// File: rtl/ghost_mode_ctrl.sv
// rtl/ghost_mode_ctrl.sv - scatter/chase phase scheduler with optional frightened overlay
// Frightened mode and pellet handling exist only when GHOST_FRIGHT_EN is defined.
module ghost_mode_ctrl #(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int SCATTER_LONG  = 7,
  parameter int SCATTER_SHORT = 5,
  parameter int CHASE_LEN     = 20,
  parameter int FRIGHT_LEN    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       power_pellet,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFright,
  output logic       reverse,
  output logic [2:0] phase
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] SEC_LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] secCnt, secCntNext;
  logic [7:0]    remain, remainNext;
  logic [2:0]    phaseNext;
  logic          scatterNext, chaseNext, reverseNext;
  logic          tick;

  // Duration of the phase being entered; phase 7 is endless so its value is never consumed.
  function automatic logic [7:0] durFor(input logic [2:0] p);
    if (p[0])
      durFor = 8'(CHASE_LEN);
    else if (p < 3'd4)
      durFor = 8'(SCATTER_LONG);
    else
      durFor = 8'(SCATTER_SHORT);
  endfunction

  assign tick = run && (secCnt == SEC_LAST);

`ifdef GHOST_FRIGHT_EN
  logic       frightQ, frightNext;
  logic [7:0] frightRemain, frightRemainNext;
  logic       pelletHit;

  assign pelletHit = run && power_pellet;
  assign isFright  = frightQ;
`else
  logic unusedPellet;
  assign unusedPellet = power_pellet & (FRIGHT_LEN != 0);
  assign isFright     = 1'b0;
`endif

  always_comb begin
    secCntNext  = secCnt;
    remainNext  = remain;
    phaseNext   = phase;
    scatterNext = isScatter;
    chaseNext   = isChase;
    reverseNext = 1'b0;
`ifdef GHOST_FRIGHT_EN
    frightNext       = frightQ;
    frightRemainNext = frightRemain;
`endif
    if (run) begin
      secCntNext = tick ? '0 : secCnt + 1'b1;
`ifdef GHOST_FRIGHT_EN
      // A pellet outranks a coincident phase-expiry tick; only the first pellet reverses.
      if (pelletHit) begin
        frightNext       = 1'b1;
        frightRemainNext = 8'(FRIGHT_LEN);
        secCntNext       = '0;
        scatterNext      = 1'b0;
        chaseNext        = 1'b0;
        reverseNext      = !frightQ;
      end else if (frightQ) begin
        if (tick) begin
          frightRemainNext = frightRemain - 8'd1;
          if (frightRemain == 8'd1) begin
            frightNext  = 1'b0;
            secCntNext  = '0;
            scatterNext = !phase[0];
            chaseNext   = phase[0];
          end
        end
      end else
`endif
      if (tick && phase != 3'd7) begin
        if (remain == 8'd1) begin
          phaseNext   = phase + 3'd1;
          remainNext  = durFor(phase + 3'd1);
          scatterNext = phase[0];
          chaseNext   = !phase[0];
          reverseNext = 1'b1;
        end else begin
          remainNext = remain - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      secCnt    <= '0;
      remain    <= 8'(SCATTER_LONG);
      phase     <= 3'd0;
      isScatter <= 1'b1;
      isChase   <= 1'b0;
      reverse   <= 1'b0;
    end else begin
      secCnt    <= secCntNext;
      remain    <= remainNext;
      phase     <= phaseNext;
      isScatter <= scatterNext;
      isChase   <= chaseNext;
      reverse   <= reverseNext;
    end
  end

`ifdef GHOST_FRIGHT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frightQ      <= 1'b0;
      frightRemain <= 8'd0;
    end else begin
      frightQ      <= frightNext;
      frightRemain <= frightRemainNext;
    end
  end
`endif

endmodule

// File: doc/ghost_mode_ctrl.md
# ghost_mode_ctrl

Global ghost-behaviour scheduler. It sequences the scatter/chase phase table over game time and overlays a frightened interval when a power pellet is eaten. It drives the level-sensitive `isChase` / `isScatter` mode inputs of every ghost FSM (blinky, pinky, inky, clyde), plus a one-cycle reverse strobe on mode changes. It sits directly upstream of the ghost movement blocks and is shared by all four.

## Interface
Parameters:
- `TICKS_PER_SEC`, 25_000_000 — clk cycles per game second; set to 4 in simulation.
- `SCATTER_LONG`, 7 — seconds, phases 0 and 2.
- `SCATTER_SHORT`, 5 — seconds, phases 4 and 6.
- `CHASE_LEN`, 20 — seconds, phases 1, 3 and 5.
- `FRIGHT_LEN`, 6 — seconds of frightened mode per pellet.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `run`  in  1  game active; low freezes all timers and holds all outputs
- `power_pellet`  in  1  single-cycle pulse when Pac-Man eats a power pellet
- `isScatter`  out  1  ghosts target their home corners
- `isChase`  out  1  ghosts use their individual chase targets
- `isFright`  out  1  frightened interval active
- `reverse`  out  1  one-cycle strobe; ghosts reverse direction
- `phase`  out  3  current phase index, 0..7

## Operation
- Phase table: 0 S(SCATTER_LONG), 1 C(CHASE_LEN), 2 S(SCATTER_LONG), 3 C, 4 S(SCATTER_SHORT), 5 C, 6 S(SCATTER_SHORT), 7 C (infinite). Even phases are scatter; odd phases are chase.
- Prescaler: `sec_cnt` counts 0..TICKS_PER_SEC-1 while `run` is high. The cycle in which it wraps is a second tick. Width is `$clog2(TICKS_PER_SEC)`.
- Phase timer: `remain` (8 bits) decrements on each second tick while not frightened.
  - When a tick occurs with `remain`==1 and `phase`<7: `phase` increments, `remain` loads the next duration, `reverse`=1 for one cycle.
  - Phase 7 never decrements or advances.
- Outputs when not frightened: `isScatter` = !phase[0], `isChase` = phase[0]. They are never both 1.
- Frightened, compiled in per Configuration:
  - Entry: `power_pellet` while `run`=1 and not frightened sets `isFright`=1, clears `isChase` and `isScatter`, loads `fright_remain`=FRIGHT_LEN, clears `sec_cnt`, and pulses `reverse`.
  - While frightened, second ticks decrement `fright_remain`; `phase`/`remain` are frozen.
  - A pellet during fright reloads FRIGHT_LEN and clears `sec_cnt`, with no `reverse`.
  - Exit on the tick with `fright_remain`==1: `isFright`=0, phase outputs restored, `sec_cnt` cleared, no `reverse`.
- `run`=0: all counters hold, outputs hold, `reverse`=0, `power_pellet` ignored.
- Reset values: `phase`=0, `remain`=SCATTER_LONG, `sec_cnt`=0, `isScatter`=1, `isChase`=0, `isFright`=0, `reverse`=0, `fright_remain`=0.

## Timing
- All outputs are registered and update on the clk edge after the causing condition (tick or pellet).
- Phase-change latency from reset release with `run`=1: phase 0→1 occurs exactly SCATTER_LONG×TICKS_PER_SEC cycles after the first counting cycle.
- `reverse` is high for exactly one cycle, coincident with the first cycle of the new mode outputs.
- Simultaneous pellet and phase-expiry tick: the pellet wins. Fright is entered, the phase does not advance (`remain` stays 1), and one `reverse` pulse is issued.
- Asynchronous `reset` mid-phase or mid-fright returns immediately to the reset values.

## Configuration
- `GHOST_FRIGHT_EN` defined: frightened logic, `fright_remain`, and pellet handling are present as described.
- Undefined: `power_pellet` is ignored, `isFright` is tied to 0, and no fright registers are synthesized. The phase schedule is unchanged.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset, `run`=1 → `isScatter`=1; at cycle 28 `phase`=1, `isChase`=1, `isScatter`=0, and `reverse` high for 1 cycle.
- Run the full schedule → phases advance at cumulative cycles 28, 108, 136, 216, 236, 316, 336; `phase` stays 7 for ≥1000 further cycles with no `reverse`.
- `run` low for 50 cycles in mid-phase 1 → `phase` and outputs hold, no `reverse`; the transition to phase 2 is delayed by exactly 50 cycles.
- `power_pellet` at cycle 40 → `isFright`=1, `isChase`=`isScatter`=0, `reverse` pulse; `isFright` clears 24 cycles later; `isChase`=1 and `phase`=1 resume.
- Second pellet 10 cycles into fright → no `reverse`; fright ends 24 cycles after the second pellet.
- Pellet on the exact cycle of the phase-0 expiry tick → fright entered, `phase` remains 0, and exactly one `reverse` pulse.
